// File: rtl/ltc2324_16_capture_if.sv
// ltc2324_16_capture_if: valid/ready frame stream from the capture front-end to the packer.
interface ltc2324_16_capture_if;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  modport master (output m_data, m_valid, input m_ready);
  modport slave  (input m_data, m_valid, output m_ready);
endinterface

// File: rtl/ltc2324_16_capture.sv
// ltc2324_16_capture: LTC2324-16 CNV/SCK sequencer and 4-lane deserialiser producing one 64-bit frame per conversion.
// Define LTC2324_TEST_PATTERN_EN to replace SDO data with a counting pattern (ch_k = 4*n + k-1).
module ltc2324_16_capture #(
  parameter int CNV_HIGH_CYCLES = 2,
  parameter int CONV_CYCLES     = 18
) (
  input  logic                         adc_clk,
  input  logic                         adc_rst_n,
  input  logic                         sample_start,
  input  logic [31:0]                  sample_len,
  output logic                         adc_CNV,
  output logic                         adc_SCK,
  input  logic                         adc_SDO1,
  input  logic                         adc_SDO2,
  input  logic                         adc_SDO3,
  input  logic                         adc_SDO4,
  ltc2324_16_capture_if.master         m,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);
  typedef enum logic [2:0] {IDLE, ZERO, CNV_HI, CONV_WAIT, SHIFT, EMIT} state_t;
  state_t             state_q;
  logic [2:0]         sync_q;
  logic [31:0]        remaining_q;
  logic [15:0]        cnt_q;
  logic [3:0][15:0]   sr_q;
  logic [63:0]        data_q;
  logic [63:0]        frame_d;
  logic               valid_q, cnv_q, sck_q, busy_q, done_q, overrun_q;
  logic               start_edge, emit, hold;
`ifdef LTC2324_TEST_PATTERN_EN
  logic [15:0]        fidx_q;
  logic [15:0]        base;
  always_comb begin
    base    = {fidx_q[13:0], 2'b00};
    frame_d = {base | 16'd3, base | 16'd2, base | 16'd1, base};
  end
`else
  always_comb frame_d = sr_q;
`endif
  assign start_edge = sync_q[1] & ~sync_q[2];
  assign emit       = state_q == EMIT;
  // a frame that arrives while the old one is still unaccepted is dropped
  assign hold       = valid_q & ~m.m_ready;
  assign adc_CNV    = cnv_q;
  assign adc_SCK    = sck_q;
  assign m.m_data   = data_q;
  assign m.m_valid  = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cnv_q       <= 1'b0;
      sck_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef LTC2324_TEST_PATTERN_EN
      fidx_q      <= '0;
`endif
    end else begin
      sync_q <= {sync_q[1:0], sample_start};
      done_q <= 1'b0;
      if (emit && !hold) begin
        data_q  <= frame_d;
        valid_q <= 1'b1;
      end else if (valid_q && m.m_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (start_edge) begin
          remaining_q <= sample_len;
          overrun_q   <= 1'b0;
          busy_q      <= 1'b1;
          cnt_q       <= '0;
`ifdef LTC2324_TEST_PATTERN_EN
          fidx_q      <= '0;
`endif
          state_q     <= (sample_len == 32'd0) ? ZERO : CNV_HI;
          cnv_q       <= sample_len != 32'd0;
        end
        ZERO: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        CNV_HI: if (cnt_q == 16'(CNV_HIGH_CYCLES - 1)) begin
          cnt_q   <= '0;
          cnv_q   <= 1'b0;
          state_q <= CONV_WAIT;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
        CONV_WAIT: if (cnt_q == 16'(CONV_CYCLES - 1)) begin
          cnt_q   <= '0;
          sck_q   <= 1'b1;
          state_q <= SHIFT;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
        SHIFT: begin
          cnt_q <= cnt_q + 16'd1;
          // SCK is high on even cycles; data is captured as it falls
          sck_q <= cnt_q[0] && cnt_q != 16'd31;
          if (!cnt_q[0]) begin
            sr_q[0] <= {sr_q[0][14:0], adc_SDO1};
            sr_q[1] <= {sr_q[1][14:0], adc_SDO2};
            sr_q[2] <= {sr_q[2][14:0], adc_SDO3};
            sr_q[3] <= {sr_q[3][14:0], adc_SDO4};
          end
          if (cnt_q == 16'd31) state_q <= EMIT;
        end
        EMIT: begin
          remaining_q <= remaining_q - 32'd1;
          cnt_q       <= '0;
          if (hold) overrun_q <= 1'b1;
`ifdef LTC2324_TEST_PATTERN_EN
          fidx_q      <= fidx_q + 16'd1;
`endif
          if (remaining_q != 32'd1) begin
            state_q <= CNV_HI;
            cnv_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
